// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, colour width and paddle FSM encoding
package vga_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int COLOR_W  = 4;

   localparam logic [3*COLOR_W-1:0] PAD_COLOR_DEF = 12'hFF0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE_L = 2'd1,
      MOVE_R = 2'd2
   } padState_t;

endpackage

// File: rtl/vga_frame_tick.sv
// rtl/vga_frame_tick.sv - one-clock pulse at the first blanking line of each frame
module vga_frame_tick
   import vga_pkg::*;
#(
   parameter int TICK_LINE = SCREEN_H
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] pixelX,
   input  logic [9:0] pixelY,
   output logic       tick
);

   logic cond;
   logic condQ;

   // Pixel counters hold each position for several clocks; edge-detect to fire once.
   assign cond = (pixelX == 10'd0) && (pixelY == 10'(TICK_LINE));

   always_ff @(posedge clock) begin
      if (!reset) begin
         condQ <= 1'b0;
      end else begin
         condQ <= cond;
      end
   end

   assign tick = cond & ~condQ;

endmodule

// File: rtl/vga_paddle_ctrl.sv
// rtl/vga_paddle_ctrl.sv - button-driven paddle with per-frame acceleration, clamping and rendering
module vga_paddle_ctrl
   import vga_pkg::*;
#(
   parameter int                   SCREEN_W_P   = SCREEN_W,
   parameter int                   SCREEN_H_P   = SCREEN_H,
   parameter int                   PAD_W        = 64,
   parameter int                   PAD_H        = 8,
   parameter int                   PAD_Y        = 460,
   parameter int                   SPEED_MIN    = 2,
   parameter int                   SPEED_MAX    = 8,
   parameter int                   ACCEL_FRAMES = 4,
   parameter logic [3*COLOR_W-1:0] PAD_COLOR    = PAD_COLOR_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               videoON,
   input  logic [9:0]         pixelX,
   input  logic [9:0]         pixelY,
   input  logic               btnLeft,
   input  logic               btnRight,
   output logic [COLOR_W-1:0] vgaRed,
   output logic [COLOR_W-1:0] vgaGreen,
   output logic [COLOR_W-1:0] vgaBlue,
   output logic               barWire,
   output logic [9:0]         paddleX
);

   localparam int         MAX_X    = SCREEN_W_P - PAD_W;
   localparam logic [9:0] CENTER_X = 10'((SCREEN_W_P - PAD_W) / 2);
   localparam logic [9:0] SPD_MIN  = 10'(SPEED_MIN);
   localparam logic [9:0] SPD_MAX  = 10'(SPEED_MAX);
   localparam logic [7:0] CNT_LAST = 8'(ACCEL_FRAMES - 1);

   logic       leftMeta, leftSync;
   logic       rightMeta, rightSync;
   logic       tick;

   padState_t  state, nextState;
   logic [9:0] speed, nextSpeed;
   logic [7:0] frameCnt, nextCnt;
   logic [9:0] nextX;

   logic       entering;
   logic [9:0] effSpeed;
   logic [7:0] effCnt;
   logic [10:0] sumExt;

   logic       hit;
   logic [10:0] pxExt, pyExt, leftExt;

   always_ff @(posedge clock) begin
      if (!reset) begin
         leftMeta  <= 1'b0;
         leftSync  <= 1'b0;
         rightMeta <= 1'b0;
         rightSync <= 1'b0;
      end else begin
         leftMeta  <= btnLeft;
         leftSync  <= leftMeta;
         rightMeta <= btnRight;
         rightSync <= rightMeta;
      end
   end

   vga_frame_tick #(
      .TICK_LINE (SCREEN_H_P)
   ) frameTick (
      .clock  (clock),
      .reset  (reset),
      .pixelX (pixelX),
      .pixelY (pixelY),
      .tick   (tick)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         speed    <= SPD_MIN;
         frameCnt <= 8'd0;
         paddleX  <= CENTER_X;
      end else begin
         state    <= nextState;
         speed    <= nextSpeed;
         frameCnt <= nextCnt;
         paddleX  <= nextX;
      end
   end

   // A move on the same clock as entry must already use the restarted speed.
   always_comb begin
      nextState = IDLE;
      nextSpeed = speed;
      nextCnt   = frameCnt;
      nextX     = paddleX;
      entering  = 1'b0;
      effSpeed  = speed;
      effCnt    = frameCnt;
      sumExt    = {1'b0, paddleX} + {1'b0, speed};

      case ({leftSync, rightSync})
         2'b10:   nextState = MOVE_L;
         2'b01:   nextState = MOVE_R;
         default: nextState = IDLE;
      endcase

      entering = (nextState != IDLE) && (nextState != state);
      if (entering) begin
         effSpeed  = SPD_MIN;
         effCnt    = 8'd0;
         nextSpeed = SPD_MIN;
         nextCnt   = 8'd0;
      end
      sumExt = {1'b0, paddleX} + {1'b0, effSpeed};

      if (tick && (nextState != IDLE)) begin
         if (nextState == MOVE_L) begin
            nextX = (paddleX < effSpeed) ? 10'd0 : (paddleX - effSpeed);
         end else begin
            nextX = (sumExt > 11'(MAX_X)) ? 10'(MAX_X) : sumExt[9:0];
         end

         if (effCnt == CNT_LAST) begin
            nextCnt   = 8'd0;
            nextSpeed = (effSpeed >= SPD_MAX) ? SPD_MAX : (effSpeed + 10'd1);
         end else begin
            nextCnt   = effCnt + 8'd1;
            nextSpeed = effSpeed;
         end
      end
   end

   assign pxExt   = {1'b0, pixelX};
   assign pyExt   = {1'b0, pixelY};
   assign leftExt = {1'b0, paddleX};

   assign hit = (pxExt >= leftExt) && (pxExt < leftExt + 11'(PAD_W)) &&
                (pyExt >= 11'(PAD_Y)) && (pyExt < 11'(PAD_Y + PAD_H));

   always_ff @(posedge clock) begin
      if (!reset) begin
         barWire  <= 1'b0;
         vgaRed   <= '0;
         vgaGreen <= '0;
         vgaBlue  <= '0;
      end else begin
         barWire <= hit;
         if (videoON && hit) begin
            {vgaRed, vgaGreen, vgaBlue} <= PAD_COLOR;
         end else begin
            {vgaRed, vgaGreen, vgaBlue} <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_paddle_ctrl.sv
// tb/tb_vga_paddle_ctrl.sv - self-checking bench for vga_paddle_ctrl
module tb_vga_paddle_ctrl;

   logic       clock    = 1'b0;
   logic       reset    = 1'b0;
   logic       videoON  = 1'b0;
   logic       btnLeft  = 1'b0;
   logic       btnRight = 1'b0;
   logic [9:0] pixelX   = 10'd5;
   logic [9:0] pixelY   = 10'd481;
   logic [3:0] vgaRed, vgaGreen, vgaBlue;
   logic       barWire;
   logic [9:0] paddleX;

   always #5 clock = ~clock;

   vga_paddle_ctrl dut (
      .clock    (clock),
      .reset    (reset),
      .videoON  (videoON),
      .pixelX   (pixelX),
      .pixelY   (pixelY),
      .btnLeft  (btnLeft),
      .btnRight (btnRight),
      .vgaRed   (vgaRed),
      .vgaGreen (vgaGreen),
      .vgaBlue  (vgaBlue),
      .barWire  (barWire),
      .paddleX  (paddleX)
   );

   int checks   = 0;
   int failures = 0;

   // Model: paddle position as a function of frames elapsed in the current held direction.
   int          mX        = 288;
   int          mRun      = 0;
   int          mPrevDir  = 0;
   bit          mPrevCond = 1'b0;
   bit          mValid    = 1'b0;
   bit          expBar    = 1'b0;
   logic [11:0] expRgb    = 12'h000;

   function automatic int dirOf(input logic l, input logic r);
      if (l && !r) return 1;
      if (r && !l) return 2;
      return 0;
   endfunction

   function automatic int stepFor(input int run);
      int s;
      s = 2 + run / 4;
      return (s > 8) ? 8 : s;
   endfunction

   function automatic int moveTo(input int x, input int dir, input int s);
      if (dir == 1) return (x < s) ? 0 : x - s;
      return (x + s > 576) ? 576 : x + s;
   endfunction

   function automatic bit onPaddle(input int px, input int py, input int x);
      return (px >= x) && (px < x + 64) && (py >= 460) && (py < 468);
   endfunction

   int curDir;
   int curRun;
   bit frameCond;
   assign curDir    = dirOf(btnLeft, btnRight);
   assign curRun    = (curDir != mPrevDir) ? 0 : mRun;
   assign frameCond = (pixelX == 10'd0) && (pixelY == 10'd480);

   always @(posedge clock) begin
      if (!reset) begin
         mX        <= 288;
         mRun      <= 0;
         mPrevDir  <= 0;
         mPrevCond <= 1'b0;
         expBar    <= 1'b0;
         expRgb    <= 12'h000;
         mValid    <= 1'b1;
      end else begin
         expBar    <= onPaddle(int'(pixelX), int'(pixelY), mX);
         expRgb    <= (videoON && onPaddle(int'(pixelX), int'(pixelY), mX)) ? 12'hFF0 : 12'h000;
         mPrevCond <= frameCond;
         mPrevDir  <= curDir;
         if (frameCond && !mPrevCond && curDir != 0) begin
            mX   <= moveTo(mX, curDir, stepFor(curRun));
            mRun <= curRun + 1;
         end else begin
            mRun <= curRun;
         end
      end
   end

   int    litReq  = 0;
   int    litSeen = 0;
   int    litX    = -1;
   int    litBar  = -1;
   int    litRgb  = -1;
   string litName = "";

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (mValid) begin
            chk("paddleX", int'(paddleX), mX);
            chk("barWire", int'(barWire), int'(expBar));
            chk("rgb", int'({vgaRed, vgaGreen, vgaBlue}), int'(expRgb));
         end
         if (litReq != litSeen) begin
            litSeen = litReq;
            if (litX >= 0)   chk({litName, "_x"}, int'(paddleX), litX);
            if (litBar >= 0) chk({litName, "_bar"}, int'(barWire), litBar);
            if (litRgb >= 0) chk({litName, "_rgb"}, int'({vgaRed, vgaGreen, vgaBlue}), litRgb);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic lit(input string nm, input int x, input int bar, input int rgb);
      litName = nm;
      litX    = x;
      litBar  = bar;
      litRgb  = rgb;
      litReq++;
      @(negedge clock);
      #1;
   endtask

   task automatic frame();
      pixelX = 10'd0;
      pixelY = 10'd480;
      step(4);
      pixelX = 10'd5;
      pixelY = 10'd481;
      step(3);
   endtask

   int accelExp[5] = '{290, 292, 294, 296, 299};

   initial begin
      step(2);
      lit("reset", 288, 0, 0);
      reset = 1'b1;
      step(1);

      btnRight = 1'b1;
      step(4);
      for (int i = 0; i < 5; i++) begin
         frame();
         lit("accel", accelExp[i], -1, -1);
      end
      repeat (80) frame();
      lit("rclamp", 576, -1, -1);
      frame();
      lit("rhold", 576, -1, -1);

      btnRight = 1'b0;
      reset    = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
      lit("recenter", 288, 0, 0);

      btnLeft = 1'b1;
      step(4);
      repeat (4) frame();
      lit("left4", 280, -1, -1);
      btnLeft  = 1'b0;
      btnRight = 1'b1;
      step(4);
      frame();
      lit("reverse", 282, -1, -1);

      btnLeft = 1'b1;
      step(4);
      repeat (10) frame();
      lit("both", 282, -1, -1);

      btnRight = 1'b0;
      step(4);
      repeat (70) frame();
      lit("lclamp", 0, -1, -1);
      frame();
      lit("lhold", 0, -1, -1);

      btnLeft = 1'b0;
      reset   = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);

      pixelX  = 10'd288;
      pixelY  = 10'd460;
      videoON = 1'b1;
      step(1);
      lit("hitOn", 288, 1, 12'hFF0);
      videoON = 1'b0;
      step(1);
      lit("blank", -1, 1, 0);
      videoON = 1'b1;
      pixelX  = 10'd352;
      step(1);
      lit("rightEdge", -1, 0, 0);
      pixelX = 10'd351;
      pixelY = 10'd467;
      step(1);
      lit("corner", -1, 1, 12'hFF0);
      pixelY = 10'd468;
      step(1);
      lit("below", -1, 0, 0);
      pixelX = 10'd287;
      pixelY = 10'd460;
      step(1);
      lit("leftOut", -1, 0, 0);
      videoON = 1'b0;
      pixelX  = 10'd5;
      pixelY  = 10'd481;
      step(1);

      btnLeft = 1'b1;
      step(4);
      frame();
      frame();
      lit("preMid", 284, -1, -1);
      reset = 1'b0;
      step(1);
      lit("midReset", 288, 0, 0);
      btnLeft = 1'b0;
      reset   = 1'b1;
      step(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
